// File: rtl/scaler_pkg.sv
// Shared types and defaults for the scaler frame controller.
package scaler_pkg;

    localparam int unsigned XResWidth     = 11;
    localparam int unsigned YResWidth     = 11;
    localparam int unsigned DefaultXCols  = 640;
    localparam int unsigned DefaultYLines = 480;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRun,
        StDone,
        StError
    } state_e;

endpackage

// File: rtl/scaler_frame_ctrl_if.sv
// Host-side control/status and scaler-side signals of the frame controller.
interface scaler_frame_ctrl_if #(
    parameter int unsigned OUTPUT_X_RES_WIDTH = 11,
    parameter int unsigned OUTPUT_Y_RES_WIDTH = 11
);
    logic                          enable;
    logic                          frameSync;
    logic                          cfgValid;
    logic [OUTPUT_X_RES_WIDTH-1:0] cfgXRes;
    logic [OUTPUT_Y_RES_WIDTH-1:0] cfgYRes;
    logic                          cfgNearest;
    logic                          dOutValid;
    logic                          scalerStart;
    logic [OUTPUT_X_RES_WIDTH-1:0] outputXRes;
    logic [OUTPUT_Y_RES_WIDTH-1:0] outputYRes;
    logic                          nearestNeighbor;
    logic                          busy;
    logic                          frameDone;
    logic                          frameDropped;
    logic                          timeoutErr;
    logic [15:0]                   frameCount;

    modport master (
        output enable, frameSync, cfgValid, cfgXRes, cfgYRes, cfgNearest, dOutValid,
        input  scalerStart, outputXRes, outputYRes, nearestNeighbor, busy, frameDone,
               frameDropped, timeoutErr, frameCount
    );

    modport slave (
        input  enable, frameSync, cfgValid, cfgXRes, cfgYRes, cfgNearest, dOutValid,
        output scalerStart, outputXRes, outputYRes, nearestNeighbor, busy, frameDone,
               frameDropped, timeoutErr, frameCount
    );

endinterface

// File: rtl/scaler_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear, flags expiry.
module scaler_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic clk_fast,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = enable && !clear && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/scaler_frame_ctrl.sv
// Per-frame sequencer for the scaler: start pulse, output-beat counting, timeout.
module scaler_frame_ctrl
    import scaler_pkg::*;
#(
    parameter int unsigned OUTPUT_X_RES_WIDTH = XResWidth,
    parameter int unsigned OUTPUT_Y_RES_WIDTH = YResWidth,
    parameter int unsigned START_CYCLES       = 2,
    parameter int unsigned TIMEOUT_CYCLES     = 2000000
) (
    input logic              clk_fast,
    input logic              rst_n,
    scaler_frame_ctrl_if.slave bus
);

    typedef logic [OUTPUT_X_RES_WIDTH-1:0] xres_t;
    typedef logic [OUTPUT_Y_RES_WIDTH-1:0] yres_t;

    localparam int unsigned StartW   = (START_CYCLES > 2) ? $clog2(START_CYCLES) : 1;
    localparam xres_t       XResRst  = xres_t'(DefaultXCols - 1);
    localparam yres_t       YResRst  = yres_t'(DefaultYLines - 1);
    localparam logic [StartW-1:0] StartLast = StartW'(START_CYCLES - 1);

    state_e            state_q, state_d;
    logic [StartW-1:0] start_cnt_q, start_cnt_d;
    xres_t             col_q, col_d;
    yres_t             line_q, line_d;
    xres_t             x_res_q, x_res_d, pend_x_q, pend_x_d;
    yres_t             y_res_q, y_res_d, pend_y_q, pend_y_d;
    logic              nearest_q, nearest_d, pend_nearest_q, pend_nearest_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              scaler_start_q, scaler_start_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_dropped_q, frame_dropped_d;
    logic              timeout_err_q, timeout_err_d;
    logic              load_active;
    logic              wd_expire;

    scaler_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_fast(clk_fast),
        .rst_n   (rst_n),
        .clear   (load_active || bus.dOutValid),
        .enable  (state_q == StRun),
        .expire  (wd_expire)
    );

    always_comb begin
        state_d       = state_q;
        start_cnt_d   = start_cnt_q;
        col_d         = col_q;
        line_d        = line_q;
        frame_count_d = frame_count_q;
        load_active   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.frameSync && bus.enable) begin
                    state_d     = StStart;
                    load_active = 1'b1;
                end
            end
            StStart: begin
                if (start_cnt_q == StartLast) begin
                    state_d = StRun;
                end else begin
                    start_cnt_d = start_cnt_q + StartW'(1);
                end
            end
            StRun: begin
                if (bus.dOutValid) begin
                    if (col_q == x_res_q) begin
                        col_d = '0;
                        if (line_q == y_res_q) begin
                            line_d  = '0;
                            state_d = StDone;
                        end else begin
                            line_d = line_q + yres_t'(1);
                        end
                    end else begin
                        col_d = col_q + xres_t'(1);
                    end
                end else if (wd_expire) begin
                    state_d = StError;
                end
            end
            StDone: begin
                // A sync landing on the done cycle chains straight into the next frame.
                if (bus.frameSync && bus.enable) begin
                    state_d     = StStart;
                    load_active = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StError: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_active) begin
            start_cnt_d = '0;
            col_d       = '0;
            line_d      = '0;
        end
        if (state_d == StDone) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_comb begin
        pend_x_d       = bus.cfgValid ? bus.cfgXRes : pend_x_q;
        pend_y_d       = bus.cfgValid ? bus.cfgYRes : pend_y_q;
        pend_nearest_d = bus.cfgValid ? bus.cfgNearest : pend_nearest_q;
        x_res_d        = load_active ? pend_x_q : x_res_q;
        y_res_d        = load_active ? pend_y_q : y_res_q;
        nearest_d      = load_active ? pend_nearest_q : nearest_q;

        scaler_start_d  = (state_d == StStart);
        busy_d          = (state_d == StStart) || (state_d == StRun) || (state_d == StDone);
        frame_done_d    = (state_d == StDone);
        timeout_err_d   = (state_d == StError);
        frame_dropped_d = bus.frameSync && ((state_q == StStart) || (state_q == StRun));
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            start_cnt_q     <= '0;
            col_q           <= '0;
            line_q          <= '0;
            x_res_q         <= XResRst;
            y_res_q         <= YResRst;
            nearest_q       <= 1'b0;
            pend_x_q        <= XResRst;
            pend_y_q        <= YResRst;
            pend_nearest_q  <= 1'b0;
            frame_count_q   <= '0;
            scaler_start_q  <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_dropped_q <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_cnt_q     <= start_cnt_d;
            col_q           <= col_d;
            line_q          <= line_d;
            x_res_q         <= x_res_d;
            y_res_q         <= y_res_d;
            nearest_q       <= nearest_d;
            pend_x_q        <= pend_x_d;
            pend_y_q        <= pend_y_d;
            pend_nearest_q  <= pend_nearest_d;
            frame_count_q   <= frame_count_d;
            scaler_start_q  <= scaler_start_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
            frame_dropped_q <= frame_dropped_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    assign bus.scalerStart     = scaler_start_q;
    assign bus.outputXRes      = x_res_q;
    assign bus.outputYRes      = y_res_q;
    assign bus.nearestNeighbor = nearest_q;
    assign bus.busy            = busy_q;
    assign bus.frameDone       = frame_done_q;
    assign bus.frameDropped    = frame_dropped_q;
    assign bus.timeoutErr      = timeout_err_q;
    assign bus.frameCount      = frame_count_q;

endmodule

// File: tb/tb_scaler_frame_ctrl.sv
// Directed bench for scaler_frame_ctrl with a short watchdog timeout.
module tb_scaler_frame_ctrl;

    logic clk_fast = 1'b0;
    logic rst_n    = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    always #5 clk_fast = ~clk_fast;

    scaler_frame_ctrl_if #(
        .OUTPUT_X_RES_WIDTH(11),
        .OUTPUT_Y_RES_WIDTH(11)
    ) bus ();

    scaler_frame_ctrl #(
        .OUTPUT_X_RES_WIDTH(11),
        .OUTPUT_Y_RES_WIDTH(11),
        .START_CYCLES      (2),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk_fast(clk_fast),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    task automatic step();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.frameSync  = 1'b0;
        bus.cfgValid   = 1'b0;
        bus.cfgXRes    = '0;
        bus.cfgYRes    = '0;
        bus.cfgNearest = 1'b0;
        bus.dOutValid  = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_start", 32'(bus.scalerStart), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.frameDone), 0);
        chk("rst_drop", 32'(bus.frameDropped), 0);
        chk("rst_tmo", 32'(bus.timeoutErr), 0);
        chk("rst_count", 32'(bus.frameCount), 0);
        chk("rst_xres", 32'(bus.outputXRes), 639);
        chk("rst_yres", 32'(bus.outputYRes), 479);
        chk("rst_nn", 32'(bus.nearestNeighbor), 0);
        rst_n = 1'b1;
        step();

        // Default-resolution frame; new cfg mid-RUN must not touch active settings
        bus.enable    = 1'b1;
        bus.frameSync = 1'b1;
        step();
        bus.frameSync = 1'b0;
        chk("a_start1", 32'(bus.scalerStart), 1);
        chk("a_xres", 32'(bus.outputXRes), 639);
        step();
        step();
        chk("a_run_start", 32'(bus.scalerStart), 0);
        bus.cfgValid  = 1'b1;
        bus.cfgXRes   = 11'd159;
        bus.cfgYRes   = 11'd2;
        bus.dOutValid = 1'b1;
        step();
        bus.cfgValid = 1'b0;
        step();
        step();
        bus.dOutValid = 1'b0;
        chk("a_xres_hold", 32'(bus.outputXRes), 639);
        chk("a_yres_hold", 32'(bus.outputYRes), 479);

        // Watchdog: 16 idle cycles in RUN lead to ERROR
        for (int i = 0; i < 15; i++) step();
        chk("a_tmo_early", 32'(bus.timeoutErr), 0);
        chk("a_busy_early", 32'(bus.busy), 1);
        step();
        chk("a_tmo", 32'(bus.timeoutErr), 1);
        chk("a_tmo_busy", 32'(bus.busy), 0);
        bus.frameSync = 1'b1;
        step();
        bus.frameSync = 1'b0;
        chk("a_err_sync_tmo", 32'(bus.timeoutErr), 1);
        chk("a_err_sync_drop", 32'(bus.frameDropped), 0);
        bus.enable = 1'b0;
        step();
        chk("a_err_clear", 32'(bus.timeoutErr), 0);

        // Next frame picks up the pending 159
        bus.enable    = 1'b1;
        bus.frameSync = 1'b1;
        step();
        bus.frameSync = 1'b0;
        chk("a_load_x", 32'(bus.outputXRes), 159);
        chk("a_load_y", 32'(bus.outputYRes), 2);
        step();
        step();
        bus.dOutValid = 1'b1;
        step();
        step();

        // Asynchronous reset mid-RUN
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_xres", 32'(bus.outputXRes), 639);
        chk("r_busy", 32'(bus.busy), 0);
        chk("r_count", 32'(bus.frameCount), 0);
        chk("r_start", 32'(bus.scalerStart), 0);
        step();
        bus.dOutValid = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        chk("r_nodone", 32'(bus.frameDone), 0);
        chk("r_idle", 32'(bus.busy), 0);

        // 4x2 frame: 8 beats
        bus.cfgValid   = 1'b1;
        bus.cfgXRes    = 11'd3;
        bus.cfgYRes    = 11'd1;
        bus.cfgNearest = 1'b1;
        step();
        bus.cfgValid = 1'b0;
        chk("b_pend_only", 32'(bus.outputXRes), 639);
        chk("b_pend_nn", 32'(bus.nearestNeighbor), 0);
        bus.frameSync = 1'b1;
        step();
        bus.frameSync = 1'b0;
        chk("b_start1", 32'(bus.scalerStart), 1);
        chk("b_xres", 32'(bus.outputXRes), 3);
        chk("b_yres", 32'(bus.outputYRes), 1);
        chk("b_nn", 32'(bus.nearestNeighbor), 1);
        step();
        chk("b_start2", 32'(bus.scalerStart), 1);
        step();
        chk("b_start3", 32'(bus.scalerStart), 0);
        bus.dOutValid = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("b_done_early", 32'(bus.frameDone), 0);
        step();
        bus.dOutValid = 1'b0;
        chk("b_done", 32'(bus.frameDone), 1);
        chk("b_count", 32'(bus.frameCount), 1);
        step();
        chk("b_done_pulse", 32'(bus.frameDone), 0);
        chk("b_idle", 32'(bus.busy), 0);

        // Back-to-back: frameSync on the DONE cycle
        bus.frameSync = 1'b1;
        step();
        bus.frameSync = 1'b0;
        step();
        step();
        bus.dOutValid = 1'b1;
        for (int i = 0; i < 8; i++) step();
        bus.dOutValid = 1'b0;
        chk("c_done", 32'(bus.frameDone), 1);
        chk("c_count", 32'(bus.frameCount), 2);
        bus.frameSync = 1'b1;
        step();
        bus.frameSync = 1'b0;
        chk("c_b2b_start", 32'(bus.scalerStart), 1);
        chk("c_b2b_drop", 32'(bus.frameDropped), 0);
        chk("c_b2b_count", 32'(bus.frameCount), 2);

        // Sync mid-RUN dropped; enable low mid-frame still completes
        step();
        step();
        bus.enable    = 1'b0;
        bus.dOutValid = 1'b1;
        step();
        step();
        step();
        bus.frameSync = 1'b1;
        step();
        bus.frameSync = 1'b0;
        chk("d_drop", 32'(bus.frameDropped), 1);
        chk("d_busy", 32'(bus.busy), 1);
        step();
        chk("d_drop_pulse", 32'(bus.frameDropped), 0);
        step();
        step();
        chk("d_done_early", 32'(bus.frameDone), 0);
        step();
        bus.dOutValid = 1'b0;
        chk("d_done", 32'(bus.frameDone), 1);
        chk("d_count", 32'(bus.frameCount), 3);
        step();
        chk("d_idle", 32'(bus.busy), 0);

        // frameSync with enable low in IDLE is ignored silently
        bus.frameSync = 1'b1;
        step();
        bus.frameSync = 1'b0;
        chk("e_ignore_busy", 32'(bus.busy), 0);
        chk("e_ignore_drop", 32'(bus.frameDropped), 0);
        step();
        chk("e_ignore_start", 32'(bus.scalerStart), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
